// File: rtl/seq_scan_ctrl.sv
// Scan controller: takes a word over valid/ready, shifts it out MSB-first one bit per clock,
// and counts overlapping matches of a programmable pattern, reporting a count and a per-bit map.
module seq_scan_ctrl #(
  parameter int WORD_W = 16,
  parameter int PAT_W  = 4,
  parameter int CNT_W  = 5,
  parameter logic [PAT_W-1:0] PAT_RST = 4'b1011
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pat,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_word,
  output logic              in_ready,
  output logic              ser_en,
  output logic              ser_bit,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [WORD_W-1:0] match_map
);
  localparam int IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int SW = $clog2(PAT_W + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t            r_state;
  logic [WORD_W-1:0] r_word;
  logic [IW-1:0]     r_idx;
  logic [PAT_W-2:0]  r_hist;
  logic [SW-1:0]     r_seen;
  logic [PAT_W-1:0]  r_pat;
  logic              r_ser_en, r_ser_bit, r_busy, r_done;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_map;

  logic              w_accept;
  logic [PAT_W-1:0]  w_win;
  logic              w_hit;

  assign w_accept = in_valid && (r_state == S_IDLE);
  // Window ends on the bit currently on ser_bit; no match until PAT_W bits have been seen.
  assign w_win    = {r_hist, r_ser_bit};
  assign w_hit    = (r_seen >= SW'(PAT_W - 1)) && (w_win == r_pat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_word    <= '0;
      r_idx     <= '0;
      r_hist    <= '0;
      r_seen    <= '0;
      r_pat     <= PAT_RST;
      r_ser_en  <= 1'b0;
      r_ser_bit <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_cnt     <= '0;
      r_map     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_we) r_pat <= cfg_pat;
          if (w_accept) begin
            r_state   <= S_SHIFT;
            r_word    <= in_word;
            r_idx     <= IW'(WORD_W - 1);
            r_hist    <= '0;
            r_seen    <= '0;
            r_cnt     <= '0;
            r_map     <= '0;
            r_ser_en  <= 1'b1;
            r_busy    <= 1'b1;
            r_ser_bit <= in_word[WORD_W-1];
          end
        end
        S_SHIFT: begin
          if (w_hit) begin
            r_cnt        <= r_cnt + 1'b1;
            r_map[r_idx] <= 1'b1;
          end
          r_hist <= w_win[PAT_W-2:0];
          if (r_seen != SW'(PAT_W)) r_seen <= r_seen + 1'b1;
          if (r_idx == '0) begin
            r_state   <= S_DONE;
            r_ser_en  <= 1'b0;
            r_ser_bit <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end else begin
            r_idx     <= r_idx - 1'b1;
            r_ser_bit <= r_word[r_idx - 1'b1];
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign ser_en    = r_ser_en;
  assign ser_bit   = r_ser_bit;
  assign busy      = r_busy;
  assign done      = r_done;
  assign match_cnt = r_cnt;
  assign match_map = r_map;
endmodule
